instruction_loader: RTL and testbench

// - Upstream feeder of the instruction-fetch stage's instruction-memory write port. Used during debug/program load.
// - Assembles a byte stream from the debug UART receiver into 32-bit words, MSB first.
// - Writes each word to sequential IMEM addresses starting at 0, one write-enable pulse per word.
// - Stops after storing HALT_WORD or on reaching MAX_INSTRUCTION. Reports done, word count and overflow.

---
 rtl/instruction_loader.sv | 190 +++++++++++++++++++
 tb/tb_instruction_loader.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : instruction_loader
// Description : Assembles a debug-UART byte stream (MSB first) into 32-bit
//               words and writes them to consecutive IMEM addresses from 0.
//               A load ends after HALT_WORD is stored or when IMEM is full.
//               Optional inter-byte timeout: define LOADER_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_loader #(
  parameter int               SIZE            = 32,
  parameter int               MAX_INSTRUCTION = 64,
  parameter int               ADDR_WIDTH      = $clog2(MAX_INSTRUCTION),
  parameter logic [SIZE-1:0]  HALT_WORD       = 32'hFFFF_FFFF,
  parameter int               TIMEOUT_CYCLES  = 1_000_000
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_byte_valid,
  input  logic [7:0]            i_byte,
  output logic                  o_byte_ready,
  output logic                  o_inst_write_enable,
  output logic [ADDR_WIDTH-1:0] o_write_addr,
  output logic [SIZE-1:0]       o_write_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_overflow,
  output logic                  o_timeout
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RECV  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MAX_INSTRUCTION - 1);

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [1:0]            idx_q, idx_d;
  logic [SIZE-1:0]       word_q, word_d;
  logic                  overflow_q, overflow_d;

  logic w_accept;
  logic w_tmo_fire;
  logic w_new_load;

  // Byte handshake and start qualification (start only honoured when idle/done)
  assign w_accept   = i_byte_valid && (state_q == S_RECV);
  assign w_new_load = i_start && ((state_q == S_IDLE) || (state_q == S_DONE));

`ifdef LOADER_TIMEOUT_EN
  localparam int              TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             timeout_q, timeout_d;

  // Fires on the cycle the idle gap within a partial word reaches the limit
  assign w_tmo_fire = (state_q == S_RECV) && !w_accept && (idx_q != 2'd0) &&
                      (tmo_q == TMO_LAST);

  // Inter-byte counter: only counts while a word is partially assembled
  always_comb begin
    tmo_d     = '0;
    timeout_d = timeout_q;
    if ((state_q == S_RECV) && !w_accept && (idx_q != 2'd0)) begin
      tmo_d = tmo_q + TMO_W'(1);
    end
    if (w_new_load) begin
      timeout_d = 1'b0;
    end else if (w_tmo_fire) begin
      timeout_d = 1'b1;
    end
  end

  // Timeout counter and flag registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tmo_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmo_q     <= tmo_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_timeout = timeout_q;
`else
  assign w_tmo_fire = 1'b0;
  assign o_timeout  = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; HALT_WORD takes priority over the full condition
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_start) state_d = S_RECV;
      S_RECV: begin
        if (w_accept && (idx_q == 2'd3)) begin
          state_d = S_WRITE;
        end else if (w_tmo_fire) begin
          state_d = S_DONE;
        end
      end
      S_WRITE: begin
        if ((word_q == HALT_WORD) || (addr_q == LAST_ADDR)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RECV;
        end
      end
      S_DONE:  if (i_start) state_d = S_RECV;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs decoded from the current state
  always_comb begin
    o_byte_ready        = (state_q == S_RECV);
    o_inst_write_enable = (state_q == S_WRITE);
    o_busy              = (state_q == S_RECV) || (state_q == S_WRITE);
    o_done              = (state_q == S_DONE);
  end

  // Datapath next values: word assembly, address/count stepping, overflow flag
  always_comb begin
    addr_d     = addr_q;
    count_d    = count_q;
    idx_d      = idx_q;
    word_d     = word_q;
    overflow_d = overflow_q;
    if (w_new_load) begin
      addr_d     = '0;
      count_d    = '0;
      idx_d      = 2'd0;
      overflow_d = 1'b0;
    end else if (w_accept) begin
      word_d = {word_q[SIZE-9:0], i_byte};
      idx_d  = idx_q + 2'd1;
    end else if (state_q == S_WRITE) begin
      count_d = count_q + (ADDR_WIDTH+1)'(1);
      if (word_q != HALT_WORD) begin
        if (addr_q == LAST_ADDR) begin
          overflow_d = 1'b1;
        end else begin
          addr_d = addr_q + ADDR_WIDTH'(1);
          idx_d  = 2'd0;
        end
      end
    end
  end

  // Datapath registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      addr_q     <= '0;
      count_q    <= '0;
      idx_q      <= 2'd0;
      word_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      count_q    <= count_d;
      idx_q      <= idx_d;
      word_q     <= word_d;
      overflow_q <= overflow_d;
    end
  end

  assign o_write_addr = addr_q;
  assign o_write_data = word_q;
  assign o_count      = count_q;
  assign o_overflow   = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_instruction_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_instruction_loader
// Description : Directed bench for instruction_loader (4-word IMEM, 16-cycle
//               timeout when LOADER_TIMEOUT_EN is defined).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_loader;

  localparam int MAXI = 4;
  localparam int AW   = 2;

  logic          clk;
  logic          rst;
  logic          i_start;
  logic          i_byte_valid;
  logic [7:0]    i_byte;
  logic          o_byte_ready;
  logic          o_inst_write_enable;
  logic [AW-1:0] o_write_addr;
  logic [31:0]   o_write_data;
  logic          o_busy;
  logic          o_done;
  logic [AW:0]   o_count;
  logic          o_overflow;
  logic          o_timeout;

  int checks = 0;
  int errors = 0;

  logic [31:0] wa[$];
  logic [31:0] wd[$];

  instruction_loader #(
    .MAX_INSTRUCTION(MAXI),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_start            (i_start),
    .i_byte_valid       (i_byte_valid),
    .i_byte             (i_byte),
    .o_byte_ready       (o_byte_ready),
    .o_inst_write_enable(o_inst_write_enable),
    .o_write_addr       (o_write_addr),
    .o_write_data       (o_write_data),
    .o_busy             (o_busy),
    .o_done             (o_done),
    .o_count            (o_count),
    .o_overflow         (o_overflow),
    .o_timeout          (o_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Record every IMEM write; the loader must not offer ready while writing
  always @(negedge clk) begin
    if (o_inst_write_enable === 1'b1) begin
      wa.push_back(32'(o_write_addr));
      wd.push_back(o_write_data);
      check("ready_during_write", 32'(o_byte_ready), 32'd0);
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 32'(o_byte_ready), 0);
    check({tag, "_we"},    32'(o_inst_write_enable), 0);
    check({tag, "_addr"},  32'(o_write_addr), 0);
    check({tag, "_data"},  o_write_data, 0);
    check({tag, "_busy"},  32'(o_busy), 0);
    check({tag, "_done"},  32'(o_done), 0);
    check({tag, "_count"}, 32'(o_count), 0);
    check({tag, "_ovf"},   32'(o_overflow), 0);
    check({tag, "_tmo"},   32'(o_timeout), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; i_start = 1'b0; i_byte_valid = 1'b0; i_byte = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    wa.delete();
    wd.delete();
  endtask

  task automatic start_pulse();
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  // Present a byte and hold it until the loader takes it at a rising edge
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    i_byte_valid = 1'b1;
    i_byte       = b;
    while (!o_byte_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!o_byte_ready) check("byte_accept_wait", 32'(o_byte_ready), 32'd1);
    @(posedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[31-8*i -: 8]);
      if (gap) begin
        @(negedge clk);
        i_byte_valid = 1'b0;
      end
    end
  endtask

  task automatic idle_bus();
    @(negedge clk);
    i_byte_valid = 1'b0;
  endtask

  task automatic wait_writes(input int k);
    int n;
    n = 0;
    while (wa.size() < k && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("write_count", 32'(wa.size()), 32'(k));
  endtask

  logic [31:0] exp_w[4];

  initial begin
    rst = 1'b1; i_start = 1'b0; i_byte_valid = 1'b0; i_byte = 8'h00;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Single word, loader returns to RECV for the next one
    do_reset();
    start_pulse();
    check("start_busy", 32'(o_busy), 1);
    send_word(32'h0001_0203, 1'b0);
    idle_bus();
    wait_writes(1);
    check("t1_addr", wa[0], 32'd0);
    check("t1_data", wd[0], 32'h0001_0203);
    @(negedge clk);
    check("t1_ready", 32'(o_byte_ready), 1);
    check("t1_done",  32'(o_done), 0);
    check("t1_count", 32'(o_count), 1);

    // Three words then HALT in the last slot: halt wins, no overflow
    do_reset();
    exp_w[0] = 32'h1122_3344; exp_w[1] = 32'h5566_7788;
    exp_w[2] = 32'h99AA_BBCC; exp_w[3] = 32'hFFFF_FFFF;
    start_pulse();
    for (int i = 0; i < 4; i++) send_word(exp_w[i], 1'b0);
    @(negedge clk);
    check("t2_we_n1",   32'(o_inst_write_enable), 1);
    check("t2_done_n1", 32'(o_done), 0);
    @(negedge clk);
    check("t2_done_n2", 32'(o_done), 1);
    check("t2_we_n2",   32'(o_inst_write_enable), 0);
    i_byte_valid = 1'b0;
    wait_writes(4);
    for (int i = 0; i < 4; i++) begin
      check("t2_addr", wa[i], 32'(i));
      check("t2_data", wd[i], exp_w[i]);
    end
    check("t2_count", 32'(o_count), 4);
    check("t2_ovf",   32'(o_overflow), 0);
    check("t2_busy",  32'(o_busy), 0);

    // Four non-halt words fill IMEM: overflow, no fifth write
    do_reset();
    exp_w[0] = 32'h0102_0304; exp_w[1] = 32'hA0A1_A2A3;
    exp_w[2] = 32'h0BAD_F00D; exp_w[3] = 32'h1234_5678;
    start_pulse();
    for (int i = 0; i < 4; i++) send_word(exp_w[i], 1'b0);
    @(negedge clk);
    i_byte = 8'h55;
    repeat (8) @(negedge clk);
    check("t3_writes", 32'(wa.size()), 4);
    for (int i = 0; i < 4; i++) begin
      check("t3_addr", wa[i], 32'(i));
      check("t3_data", wd[i], exp_w[i]);
    end
    check("t3_done",  32'(o_done), 1);
    check("t3_ovf",   32'(o_overflow), 1);
    check("t3_count", 32'(o_count), 4);
    check("t3_ready", 32'(o_byte_ready), 0);
    check("t3_addr_hold", 32'(o_write_addr), 3);
    i_byte_valid = 1'b0;
    start_pulse();
    check("t3_restart_done",  32'(o_done), 0);
    check("t3_restart_busy",  32'(o_busy), 1);
    check("t3_restart_ovf",   32'(o_overflow), 0);
    check("t3_restart_count", 32'(o_count), 0);
    check("t3_restart_addr",  32'(o_write_addr), 0);

    // Valid toggling every cycle must not lose or duplicate bytes
    do_reset();
    start_pulse();
    send_word(32'hDEAD_BEEF, 1'b1);
    send_word(32'hCAFE_BABE, 1'b1);
    wait_writes(2);
    check("t4_addr0", wa[0], 32'd0);
    check("t4_data0", wd[0], 32'hDEAD_BEEF);
    check("t4_addr1", wa[1], 32'd1);
    check("t4_data1", wd[1], 32'hCAFE_BABE);

    // Reset after two bytes discards the partial word
    do_reset();
    start_pulse();
    send_byte(8'hAA);
    send_byte(8'hBB);
    @(negedge clk);
    rst = 1'b1; i_byte_valid = 1'b0;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    check("t5_no_write", 32'(wa.size()), 0);
    start_pulse();
    send_word(32'h0102_0304, 1'b0);
    idle_bus();
    wait_writes(1);
    check("t5_addr", wa[0], 32'd0);
    check("t5_data", wd[0], 32'h0102_0304);

`ifdef LOADER_TIMEOUT_EN
    // One byte then silence: timeout on the 16th idle edge, no write
    do_reset();
    start_pulse();
    send_byte(8'h77);
    i_byte_valid = 1'b0;
    repeat (16) @(negedge clk);
    check("t6_done_early", 32'(o_done), 0);
    @(negedge clk);
    check("t6_done",  32'(o_done), 1);
    check("t6_tmo",   32'(o_timeout), 1);
    check("t6_count", 32'(o_count), 0);
    check("t6_write", 32'(wa.size()), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
